serial_operand_loader: RTL and testbench

SERIAL_OPERAND_LOADER -- requirements
Module: serial_operand_loader

---
 rtl/serial_operand_loader.sv | 87 ++++++++
 tb/tb_serial_operand_loader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_operand_loader.sv
// Serialises a two's-complement operand pair LSB first into a downstream serial adder.
// Define SERIAL_SIGN_EXTEND_EN to add one extra sign-bit cycle (NBITS = WIDTH+1).
module serial_operand_loader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             abort,
  output logic             a,
  output logic             b,
  output logic             enable,
  output logic             adder_clr,
  output logic             busy,
  output logic             done
);

`ifdef SERIAL_SIGN_EXTEND_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SHIFT, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_a_q, sr_a_d;
  logic [WIDTH-1:0] sr_b_q, sr_b_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sr_a_q  <= '0;
      sr_b_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_a_q  <= sr_a_d;
      sr_b_q  <= sr_b_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_a_d  = sr_a_q;
    sr_b_d  = sr_b_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (load_valid) begin
          sr_a_d  = op_a;
          sr_b_d  = op_b;
          cnt_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: state_d = abort ? S_IDLE : S_SHIFT;
      S_SHIFT: begin
        // Arithmetic shift keeps the sign bit in [0] once the operand is exhausted.
        sr_a_d = {sr_a_q[WIDTH-1], sr_a_q[WIDTH-1:1]};
        sr_b_d = {sr_b_q[WIDTH-1], sr_b_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CW'(1);
        if (abort)                          state_d = S_IDLE;
        else if (cnt_q == CW'(NBITS - 1))   state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state_q == S_IDLE);
    adder_clr  = (state_q == S_CLEAR);
    enable     = (state_q == S_SHIFT);
    busy       = (state_q == S_CLEAR) || (state_q == S_SHIFT);
    done       = (state_q == S_DONE);
    a          = enable & sr_a_q[0];
    b          = enable & sr_b_q[0];
  end

endmodule

// File: tb/tb_serial_operand_loader.sv
// Directed bench for serial_operand_loader (WIDTH=8): vector table plus abort/reset/back-to-back sequences.
module tb_serial_operand_loader;
`ifdef SERIAL_SIGN_EXTEND_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_valid = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] op_a = '0, op_b = '0;
  logic       load_ready, a, b, enable, adder_clr, busy, done;

  int n_vec = 0;
  int n_err = 0;

  serial_operand_loader #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .op_a(op_a), .op_b(op_b), .abort(abort), .a(a), .b(b), .enable(enable),
    .adder_clr(adder_clr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] op_a, op_b;
    logic [8:0] ea, eb;     // expected serial streams, bit i = cycle i of SHIFT
    string      tag;
  } vec_t;

  vec_t vecs[6];

  // {load_ready, busy, done, adder_clr, enable, a, b}
  localparam logic [6:0] O_IDLE  = 7'b1000000;
  localparam logic [6:0] O_CLEAR = 7'b0101000;
  localparam logic [6:0] O_DONE  = 7'b0010000;

  function automatic logic [6:0] outs();
    return {load_ready, busy, done, adder_clr, enable, a, b};
  endfunction

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b ({rdy,busy,done,clr,en,a,b})", nm, act, exp);
    end
  endtask

  task automatic start(input logic [7:0] oa, input logic [7:0] ob, input string tag);
    @(negedge clk);
    chk({tag, " idle"}, outs(), O_IDLE);
    load_valid = 1'b1; op_a = oa; op_b = ob;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  // Runs from the cycle after accept up to and including the DONE cycle.
  task automatic expect_body(input logic [8:0] ea, input logic [8:0] eb, input string tag);
    @(negedge clk);
    chk({tag, " clear"}, outs(), O_CLEAR);
    for (int i = 0; i < NBITS; i++) begin
      @(negedge clk);
      chk($sformatf("%s bit%0d", tag, i), outs(), {5'b01001, ea[i], eb[i]});
    end
    @(negedge clk);
    chk({tag, " done"}, outs(), O_DONE);
  endtask

  initial begin
    bit done_seen;
    vecs[0] = '{8'h03, 8'h05, 9'h003, 9'h005, "basic"};
    vecs[1] = '{8'hFF, 8'h01, 9'h1FF, 9'h001, "signext"};
    vecs[2] = '{8'h80, 8'h7F, 9'h180, 9'h07F, "minmax"};
    vecs[3] = '{8'hA5, 8'h5A, 9'h1A5, 9'h05A, "alt"};
    vecs[4] = '{8'h00, 8'h00, 9'h000, 9'h000, "zero"};
    vecs[5] = '{8'h7E, 8'hC3, 9'h07E, 9'h1C3, "mixed"};

    #3;
    chk("reset state", outs(), O_IDLE);
    repeat (2) @(negedge clk);
    chk("reset held", outs(), O_IDLE);

    // First accept on the first rising edge after release.
    reset = 1'b1; load_valid = 1'b1; op_a = vecs[0].op_a; op_b = vecs[0].op_b;
    @(posedge clk); #1;
    load_valid = 1'b0;
    expect_body(vecs[0].ea, vecs[0].eb, vecs[0].tag);

    for (int v = 1; v < 6; v++) begin
      start(vecs[v].op_a, vecs[v].op_b, vecs[v].tag);
      expect_body(vecs[v].ea, vecs[v].eb, vecs[v].tag);
    end

    // Abort on the 4th SHIFT cycle.
    start(8'h55, 8'h33, "abort4");
    @(negedge clk);
    chk("abort4 clear", outs(), O_CLEAR);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("abort4 bit%0d", i), outs(), {5'b01001, 1'(8'h55 >> i), 1'(8'h33 >> i)});
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort4 idle", outs(), O_IDLE);
    done_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      done_seen |= done | enable;
    end
    chk("abort4 quiet", {6'b0, done_seen}, 7'b0);

    // Abort on the final SHIFT cycle wins over DONE.
    start(8'h0F, 8'hF0, "abortlast");
    @(negedge clk);
    chk("abortlast clear", outs(), O_CLEAR);
    for (int i = 0; i < NBITS; i++) @(negedge clk);
    chk("abortlast lastbit", outs(), {5'b01001, 1'b0, 1'b1});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abortlast idle", outs(), O_IDLE);

    // Abort during CLEAR.
    start(8'h11, 8'h22, "abortclr");
    @(negedge clk);
    chk("abortclr clear", outs(), O_CLEAR);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abortclr idle", outs(), O_IDLE);

    // Abort in IDLE (with an accept) and in DONE are ignored.
    @(negedge clk);
    load_valid = 1'b1; abort = 1'b1; op_a = 8'h96; op_b = 8'h69;
    @(posedge clk); #1;
    load_valid = 1'b0; abort = 1'b0;
    expect_body(9'h196, 9'h069, "abortidle");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abortdone idle", outs(), O_IDLE);

    // Asynchronous reset pulse mid-SHIFT.
    start(8'hA5, 8'h5A, "midrst");
    @(negedge clk);
    chk("midrst clear", outs(), O_CLEAR);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    #1 chk("midrst async", outs(), O_IDLE);
    #2 reset = 1'b1;
    start(8'h03, 8'h05, "postrst");
    expect_body(9'h003, 9'h005, "postrst");

    // Back-to-back with load_valid held; operands changed while busy must not be captured.
    @(negedge clk);
    chk("b2b idle", outs(), O_IDLE);
    load_valid = 1'b1; op_a = 8'h3C; op_b = 8'h81;
    @(posedge clk); #1;
    op_a = 8'hFF; op_b = 8'hFF;
    expect_body(9'h03C, 9'h181, "b2b1");
    op_a = 8'h12; op_b = 8'hE7;
    @(negedge clk);
    chk("b2b gap", outs(), O_IDLE);
    @(posedge clk); #1;
    load_valid = 1'b0;
    expect_body(9'h012, 9'h1E7, "b2b2");
    @(negedge clk);
    chk("b2b end", outs(), O_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
